// File: rtl/bitmap_scanner_if.sv
// Bitmap scanner bus: scan command, snapshot bitmap, pixel stream handshake and status.
// The scanner side uses the master modport; the host/consumer side uses slave.
interface bitmap_scanner_if #(
  parameter int DIM     = 64,
  parameter int COORD_W = 8,
  parameter int CNT_W   = 13
);
  logic                 start;
  logic [DIM*DIM-1:0]   bitmap;
  logic                 pix_ready;
  logic                 pix_valid;
  logic [COORD_W-1:0]   pix_x;
  logic [COORD_W-1:0]   pix_y;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     pix_count;

  modport master (
    input  start, bitmap, pix_ready,
    output pix_valid, pix_x, pix_y, busy, done, pix_count
  );

  modport slave (
    output start, bitmap, pix_ready,
    input  pix_valid, pix_x, pix_y, busy, done, pix_count
  );
endinterface

// File: rtl/bitmap_scanner.sv
// Streams the (x,y) of every set pixel of a captured DIM x DIM bitmap in row-major order.
// Define BITMAP_SCANNER_ROW_SKIP_EN to step over all-zero rows in a single cycle.
module bitmap_scanner #(
  parameter int DIM     = 64,
  parameter int COORD_W = 8,
  parameter int CNT_W   = 13
) (
  input  logic             clk,
  input  logic             n_rst,
  bitmap_scanner_if.master bus
);
  localparam int NBITS = DIM * DIM;
  localparam int IDX_W = $clog2(NBITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);
  localparam logic [IDX_W-1:0] DIM_IDX  = IDX_W'(DIM);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

  state_t             r_state;
  logic [NBITS-1:0]   r_snap;
  logic [IDX_W-1:0]   r_idx;
  logic               r_pix_valid;
  logic [COORD_W-1:0] r_pix_x;
  logic [COORD_W-1:0] r_pix_y;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_pix_count;

  logic               w_bit;
  logic               w_last;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;

  assign w_bit  = r_snap[r_idx];
  assign w_last = (r_idx == LAST_IDX);
  assign w_x    = COORD_W'(r_idx % DIM_IDX);
  assign w_y    = COORD_W'(r_idx / DIM_IDX);

`ifdef BITMAP_SCANNER_ROW_SKIP_EN
  logic             w_row_start;
  logic             w_row_zero;
  logic             w_last_row;
  logic [IDX_W-1:0] w_row_base;

  // Row base is always row-aligned, so the part-select never leaves the snapshot.
  assign w_row_base  = r_idx - (r_idx % DIM_IDX);
  assign w_row_start = (r_idx == w_row_base);
  assign w_row_zero  = ~|r_snap[w_row_base +: DIM];
  assign w_last_row  = (w_row_base == IDX_W'(NBITS - DIM));
`endif

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pix_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_snap      <= bus.bitmap;
            r_idx       <= '0;
            r_pix_count <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_SCAN;
          end
        end
        S_SCAN: begin
`ifdef BITMAP_SCANNER_ROW_SKIP_EN
          if (w_row_start && w_row_zero) begin
            if (w_last_row) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + DIM_IDX;
            end
          end else
`endif
          if (w_bit) begin
            r_pix_x     <= w_x;
            r_pix_y     <= w_y;
            r_pix_valid <= 1'b1;
            r_state     <= S_EMIT;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_EMIT: begin
          // Coordinates and valid are held untouched until the consumer accepts.
          if (bus.pix_ready) begin
            r_pix_valid <= 1'b0;
            r_pix_count <= r_pix_count + CNT_W'(1);
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pix_valid = r_pix_valid;
  assign bus.pix_x     = r_pix_x;
  assign bus.pix_y     = r_pix_y;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pix_count = r_pix_count;
endmodule

// File: tb/tb_bitmap_scanner.sv
// Directed self-checking bench for bitmap_scanner: reset abort, single pixel, clipped
// line, stalled corner pixels, empty bitmap and start held through a scan.
module tb_bitmap_scanner;
  localparam int DIM     = 64;
  localparam int COORD_W = 8;
  localparam int CNT_W   = 13;
  localparam int NBITS   = DIM * DIM;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  bitmap_scanner_if #(.DIM(DIM), .COORD_W(COORD_W), .CNT_W(CNT_W)) bus ();

  bitmap_scanner #(.DIM(DIM), .COORD_W(COORD_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int q_x[$];
  int q_y[$];
  int done_k;
  int first_valid_k;
  logic [NBITS-1:0] bm;
  logic [NBITS-1:0] bm_b;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NBITS-1:0] line_bm(input int x0, input int y0, input int x1, input int y1);
    logic [NBITS-1:0] b;
    int dx, dy, sx, sy, err, e2, x, y;
    b  = '0;
    x  = x0;
    y  = y0;
    dx = (x1 > x0) ? (x1 - x0) : (x0 - x1);
    dy = (y1 > y0) ? (y0 - y1) : (y1 - y0);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    for (int i = 0; i < 256; i++) begin
      if (x >= 0 && x < DIM && y >= 0 && y < DIM) b[y*DIM + x] = 1'b1;
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    return b;
  endfunction

  // Present bitmap and start for one capture edge; returns at the negedge right after it.
  task automatic launch(input logic [NBITS-1:0] b, input logic [NBITS-1:0] b_after, input bit hold);
    @(negedge clk);
    bus.bitmap    = b;
    bus.start     = 1'b1;
    bus.pix_ready = 1'b0;
    @(negedge clk);
    bus.bitmap = b_after;
    if (!hold) bus.start = 1'b0;
  endtask

  // k counts edges after the capture edge; returns at the negedge where done is seen.
  task automatic collect(input int stall);
    bit in_beat;
    bit timed_out;
    int waited;
    logic [COORD_W-1:0] hx, hy;
    in_beat = 1'b0;
    timed_out = 1'b1;
    waited = 0;
    hx = '0;
    hy = '0;
    q_x.delete();
    q_y.delete();
    done_k = -1;
    first_valid_k = -1;
    for (int k = 0; k < 6000; k++) begin
      if (bus.done) begin
        done_k = k;
        timed_out = 1'b0;
        break;
      end
      if (bus.pix_valid) begin
        if (first_valid_k < 0) first_valid_k = k;
        if (!in_beat) begin
          in_beat = 1'b1;
          hx = bus.pix_x;
          hy = bus.pix_y;
          waited = 0;
        end else begin
          check_eq("stall_x", bus.pix_x, hx);
          check_eq("stall_y", bus.pix_y, hy);
        end
        if (waited < stall) begin
          bus.pix_ready = 1'b0;
          waited++;
        end else begin
          bus.pix_ready = 1'b1;
          q_x.push_back(int'(hx));
          q_y.push_back(int'(hy));
          in_beat = 1'b0;
        end
      end else begin
        bus.pix_ready = 1'b0;
      end
      @(negedge clk);
    end
    bus.pix_ready = 1'b0;
    check_eq("scan_timeout", timed_out, 0);
  endtask

  task automatic check_done_pulse_end(input string tag);
    @(negedge clk);
    check_eq({tag, "_done_low"}, bus.done, 0);
    check_eq({tag, "_busy_low"}, bus.busy, 0);
  endtask

  initial begin
    int prev;
    int idx;
    n_rst         = 1'b1;
    bus.start     = 1'b0;
    bus.bitmap    = '0;
    bus.pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    check_eq("rst_valid", bus.pix_valid, 0);
    check_eq("rst_busy",  bus.busy, 0);
    check_eq("rst_done",  bus.done, 0);
    check_eq("rst_count", bus.pix_count, 0);
    check_eq("rst_x",     bus.pix_x, 0);
    check_eq("rst_y",     bus.pix_y, 0);

    // Reset mid-scan: pixels 0..9 of row 0, each accepted two edges apart.
    bm = '0;
    bm[9:0] = 10'h3FF;
    launch(bm, bm, 1'b0);
    bus.pix_ready = 1'b1;
    repeat (25) @(negedge clk);
    check_eq("midscan_busy",  bus.busy, 1);
    check_eq("midscan_count", bus.pix_count, 10);
    n_rst = 1'b1;
    @(negedge clk);
    n_rst = 1'b0;
    bus.pix_ready = 1'b0;
    check_eq("abort_valid", bus.pix_valid, 0);
    check_eq("abort_busy",  bus.busy, 0);
    check_eq("abort_done",  bus.done, 0);
    check_eq("abort_count", bus.pix_count, 0);

    // Single pixel at (12,12), bit 780.
    bm = '0;
    bm[12*DIM + 12] = 1'b1;
    launch(bm, bm, 1'b0);
    collect(0);
    check_eq("single_beats", q_x.size(), 1);
    if (q_x.size() > 0) begin
      check_eq("single_x", q_x[0], 12);
      check_eq("single_y", q_y[0], 12);
    end
    check_eq("single_count", bus.pix_count, 1);
`ifdef BITMAP_SCANNER_ROW_SKIP_EN
    check_eq("single_first_valid", first_valid_k, 25);
    check_eq("single_done_k", done_k, 128);
`else
    check_eq("single_first_valid", first_valid_k, 781);
    check_eq("single_done_k", done_k, 4097);
`endif
    check_done_pulse_end("single");

    // Steep line (12,12)->(45,69) clipped at y=63: one pixel per row 12..63.
    bm = line_bm(12, 12, 45, 69);
    launch(bm, bm, 1'b0);
    collect(0);
    check_eq("line_beats", q_x.size(), 52);
    check_eq("line_count", bus.pix_count, 52);
    prev = -1;
    foreach (q_x[i]) begin
      idx = q_y[i] * DIM + q_x[i];
      check_eq("line_order", idx > prev, 1);
      check_eq("line_member", (idx < NBITS) ? bm[idx] : 1'b0, 1);
      prev = idx;
    end
    if (q_x.size() > 0) begin
      check_eq("line_first_x", q_x[0], 12);
      check_eq("line_first_y", q_y[0], 12);
    end
    check_done_pulse_end("line");

    // Corners (0,0) and (63,63), each beat stalled 5 cycles.
    bm = '0;
    bm[0] = 1'b1;
    bm[NBITS-1] = 1'b1;
    launch(bm, bm, 1'b0);
    collect(5);
    check_eq("corner_first_valid", first_valid_k, 1);
    check_eq("corner_beats", q_x.size(), 2);
    if (q_x.size() == 2) begin
      check_eq("corner0_x", q_x[0], 0);
      check_eq("corner0_y", q_y[0], 0);
      check_eq("corner1_x", q_x[1], 63);
      check_eq("corner1_y", q_y[1], 63);
    end
    check_eq("corner_count", bus.pix_count, 2);
    check_done_pulse_end("corner");

    // Empty bitmap.
    launch('0, '0, 1'b0);
    collect(0);
    check_eq("empty_beats", q_x.size(), 0);
    check_eq("empty_valid_seen", first_valid_k, -1);
`ifdef BITMAP_SCANNER_ROW_SKIP_EN
    check_eq("empty_done_k", done_k, 64);
`else
    check_eq("empty_done_k", done_k, 4096);
`endif
    check_eq("empty_count", bus.pix_count, 0);
    check_done_pulse_end("empty");

    // Start held high and bitmap swapped after capture: first scan sees only (5,0).
    bm = '0;
    bm[5] = 1'b1;
    bm_b = '0;
    bm_b[7*DIM + 7] = 1'b1;
    launch(bm, bm_b, 1'b1);
    collect(0);
    check_eq("hold_beats", q_x.size(), 1);
    if (q_x.size() > 0) begin
      check_eq("hold_x", q_x[0], 5);
      check_eq("hold_y", q_y[0], 0);
    end
    check_eq("hold_count", bus.pix_count, 1);
    check_done_pulse_end("hold");
    @(negedge clk);
    check_eq("hold_restart_busy", bus.busy, 1);
    bus.start = 1'b0;
    collect(0);
    check_eq("rescan_beats", q_x.size(), 1);
    if (q_x.size() > 0) begin
      check_eq("rescan_x", q_x[0], 7);
      check_eq("rescan_y", q_y[0], 7);
    end
    check_eq("rescan_count", bus.pix_count, 1);
    check_done_pulse_end("rescan");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
